// File: rtl/sdram_timing_pkg.sv
// Shared encodings and legacy timing defaults for the SDRAM timing counter.
package sdram_timing_pkg;

    // Config register select on ProgSel; codes 5..7 are ignored by the register file
    typedef enum logic [2:0] {
        ProgTPre   = 3'd0,
        ProgTCas   = 3'd1,
        ProgTBurst = 3'd2,
        ProgTWait  = 3'd3,
        ProgTLat   = 3'd4
    } progSel_t;

    // Per-channel timing select on LoadSel
    typedef enum logic [1:0] {
        LoadTPre   = 2'd0,
        LoadTCas   = 2'd1,
        LoadTBurst = 2'd2,
        LoadTWait  = 2'd3
    } loadSel_t;

    // Legacy timing applied at reset
    localparam int unsigned DefTPre   = 4;
    localparam int unsigned DefTCas   = 6;
    localparam int unsigned DefTBurst = 7;
    localparam int unsigned DefTWait  = 4;
    localparam int unsigned DefTLat   = 0;

    // Clamp a value to the largest number representable in width bits
    function automatic int unsigned satValue(input int unsigned value, input int unsigned width);
        int unsigned maxVal;
        maxVal = (32'd1 << width) - 32'd1;
        return (value > maxVal) ? maxVal : value;
    endfunction

endpackage

// File: rtl/sdram_timing_counter_if.sv
// Programming and per-channel control/status bundle for sdram_timing_counter.
interface sdram_timing_counter_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 4,
    parameter int unsigned PW  = 10
);
    logic [PW-1:0]     ProgramData;
    logic              ProgWrite;
    logic [2:0]        ProgSel;
    logic [NCH-1:0]    Load;
    logic [2*NCH-1:0]  LoadSel;
    logic [NCH-1:0]    Hold;
    logic [CW*NCH-1:0] CountOut;
    logic [NCH-1:0]    Done;
    logic [NCH-1:0]    Busy;
    logic [1:0]        tLAT;

    modport master (
        output ProgramData, ProgWrite, ProgSel, Load, LoadSel, Hold,
        input  CountOut, Done, Busy, tLAT
    );

    modport slave (
        input  ProgramData, ProgWrite, ProgSel, Load, LoadSel, Hold,
        output CountOut, Done, Busy, tLAT
    );
endinterface

// File: rtl/sdram_tcount_chan.sv
// One timing channel: loadable down-counter with expiry pulse and busy flag.
module sdram_tcount_chan #(
    parameter int unsigned CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] loadValue,
    input  logic          hold,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          busy
);
    logic [CW-1:0] countQ, countD;
    logic          doneQ, doneD;

    // Next count: Load wins over decrement; Hold only pauses decrement; floor at zero
    always_comb begin
        countD = countQ;
        doneD  = 1'b0;
        if (load) begin
            countD = loadValue;
            // Loading zero counts as an immediate expiry; a nonzero load masks a 1->0 step
            doneD  = (loadValue == '0);
        end else if (!hold && (countQ != '0)) begin
            countD = countQ - CW'(1);
            doneD  = (countQ == CW'(1));
        end
    end

    // Count and Done registers; reset clears both with no expiry pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            countQ <= '0;
            doneQ  <= 1'b0;
        end else begin
            countQ <= countD;
            doneQ  <= doneD;
        end
    end

    assign count = countQ;
    assign done  = doneQ;
    assign busy  = (countQ != '0);

endmodule

// File: rtl/sdram_timing_counter.sv
// Per-bank SDRAM timing counters sharing one programmable timing register file.
module sdram_timing_counter
    import sdram_timing_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 4,
    parameter int unsigned PW  = 10
) (
    input logic                   clock,
    input logic                   reset,
    sdram_timing_counter_if.slave bus
);
    localparam int unsigned MaxCount = (32'd1 << CW) - 32'd1;

    logic [CW-1:0] tPreQ, tPreD;
    logic [CW-1:0] tCasQ, tCasD;
    logic [CW-1:0] tBurstQ, tBurstD;
    logic [CW-1:0] tWaitQ, tWaitD;
    logic [1:0]    tLatQ, tLatD;
    logic [31:0]   dataWide;
    logic [CW-1:0] progSat;

    // Register-file write: saturate timing values to CW bits, tLAT takes the low two bits
    always_comb begin
        dataWide = 32'(bus.ProgramData);
        progSat  = (dataWide > MaxCount) ? CW'(MaxCount) : CW'(dataWide);
        tPreD    = tPreQ;
        tCasD    = tCasQ;
        tBurstD  = tBurstQ;
        tWaitD   = tWaitQ;
        tLatD    = tLatQ;
        if (bus.ProgWrite) begin
            case (bus.ProgSel)
                ProgTPre:   tPreD   = progSat;
                ProgTCas:   tCasD   = progSat;
                ProgTBurst: tBurstD = progSat;
                ProgTWait:  tWaitD  = progSat;
                ProgTLat:   tLatD   = bus.ProgramData[1:0];
                default:    ;
            endcase
        end
    end

    // Config registers; loads this cycle see the old values since these update on the edge
    always_ff @(posedge clock) begin
        if (reset) begin
            tPreQ   <= CW'(satValue(DefTPre, CW));
            tCasQ   <= CW'(satValue(DefTCas, CW));
            tBurstQ <= CW'(satValue(DefTBurst, CW));
            tWaitQ  <= CW'(satValue(DefTWait, CW));
            tLatQ   <= 2'(DefTLat);
        end else begin
            tPreQ   <= tPreD;
            tCasQ   <= tCasD;
            tBurstQ <= tBurstD;
            tWaitQ  <= tWaitD;
            tLatQ   <= tLatD;
        end
    end

    assign bus.tLAT = tLatQ;

    for (genvar i = 0; i < NCH; i++) begin : gChan
        logic [CW-1:0] loadValue;

        // Pick this channel's load value from its two LoadSel bits
        always_comb begin
            loadValue = tPreQ;
            case (bus.LoadSel[2*i +: 2])
                LoadTPre:   loadValue = tPreQ;
                LoadTCas:   loadValue = tCasQ;
                LoadTBurst: loadValue = tBurstQ;
                LoadTWait:  loadValue = tWaitQ;
                default:    loadValue = tPreQ;
            endcase
        end

        sdram_tcount_chan #(
            .CW(CW)
        ) uChan (
            .clock     (clock),
            .reset     (reset),
            .load      (bus.Load[i]),
            .loadValue (loadValue),
            .hold      (bus.Hold[i]),
            .count     (bus.CountOut[CW*i +: CW]),
            .done      (bus.Done[i]),
            .busy      (bus.Busy[i])
        );
    end

endmodule

// File: tb/tb_sdram_timing_counter.sv
// Directed bench for sdram_timing_counter; inputs change and outputs are sampled on negedge.
module tb_sdram_timing_counter;
    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned PW  = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nFail = 0;

    always #5 clock = ~clock;

    sdram_timing_counter_if #(.NCH(NCH), .CW(CW), .PW(PW)) bus ();

    sdram_timing_counter #(
        .NCH(NCH),
        .CW (CW),
        .PW (PW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [CW-1:0] cnt(input int i);
        return bus.CountOut[CW*i +: CW];
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        bus.ProgramData = '0;
        bus.ProgWrite   = 1'b0;
        bus.ProgSel     = 3'd0;
        bus.Load        = '0;
        bus.LoadSel     = '0;
        bus.Hold        = '0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        nChecks++;
        if (bus.CountOut !== '0) begin
            nFail++; $display("FAIL reset_count: got %h expected 0", bus.CountOut);
        end
        nChecks++;
        if (bus.Done !== '0) begin
            nFail++; $display("FAIL reset_done: got %b expected 0", bus.Done);
        end
        nChecks++;
        if (bus.Busy !== '0) begin
            nFail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy);
        end
        nChecks++;
        if (bus.tLAT !== 2'd0) begin
            nFail++; $display("FAIL reset_tlat: got %0d expected 0", bus.tLAT);
        end
        // Default config via simultaneous loads: ch0 tPRE, ch1 tCAS, ch2 tBURST, ch3 tWAIT
        bus.Load    = 4'hF;
        bus.LoadSel = 8'b11_10_01_00;
        step();
        idle();
        nChecks++;
        if (bus.CountOut !== 16'h4764) begin
            nFail++; $display("FAIL reset_defaults: got %h expected 4764", bus.CountOut);
        end
        nChecks++;
        if (bus.Busy !== 4'hF) begin
            nFail++; $display("FAIL defaults_busy: got %b expected 1111", bus.Busy);
        end
    endtask

    task automatic test_cas_countdown();
        applyReset();
        bus.Load    = 4'b0001;
        bus.LoadSel = 8'h01;
        step();
        idle();
        nChecks++;
        if (cnt(0) !== 4'd6 || bus.Done[0] !== 1'b0) begin
            nFail++; $display("FAIL cas_load: count=%0d done=%b expected 6/0", cnt(0), bus.Done[0]);
        end
        for (int k = 5; k >= 0; k--) begin
            step();
            nChecks++;
            if (cnt(0) !== 4'(k) || bus.Done[0] !== (k == 0)) begin
                nFail++;
                $display("FAIL cas_countdown: count=%0d done=%b expected %0d/%0d",
                         cnt(0), bus.Done[0], k, (k == 0));
            end
        end
        step();
        nChecks++;
        if (cnt(0) !== 4'd0 || bus.Done[0] !== 1'b0 || bus.Busy[0] !== 1'b0) begin
            nFail++;
            $display("FAIL cas_floor: count=%0d done=%b busy=%b expected 0/0/0",
                     cnt(0), bus.Done[0], bus.Busy[0]);
        end
    endtask

    task automatic test_program();
        applyReset();
        bus.ProgWrite   = 1'b1;
        bus.ProgSel     = 3'd0;
        bus.ProgramData = 10'd20;
        step();
        idle();
        bus.Load = 4'b0001;
        step();
        idle();
        nChecks++;
        if (cnt(0) !== 4'd15) begin
            nFail++; $display("FAIL prog_saturate: count=%0d expected 15", cnt(0));
        end
        bus.ProgWrite   = 1'b1;
        bus.ProgSel     = 3'd4;
        bus.ProgramData = 10'd3;
        step();
        idle();
        nChecks++;
        if (bus.tLAT !== 2'd3) begin
            nFail++; $display("FAIL prog_tlat: got %0d expected 3", bus.tLAT);
        end
        // Unused select code must not disturb anything
        bus.ProgWrite   = 1'b1;
        bus.ProgSel     = 3'd5;
        bus.ProgramData = 10'd1;
        step();
        idle();
        bus.Load = 4'b0001;
        step();
        idle();
        nChecks++;
        if (bus.tLAT !== 2'd3 || cnt(0) !== 4'd15) begin
            nFail++;
            $display("FAIL prog_ignored: tlat=%0d count=%0d expected 3/15", bus.tLAT, cnt(0));
        end
    endtask

    task automatic test_write_load_same();
        applyReset();
        bus.ProgWrite   = 1'b1;
        bus.ProgSel     = 3'd1;
        bus.ProgramData = 10'd2;
        bus.Load        = 4'b0010;
        bus.LoadSel     = 8'h04;
        step();
        bus.ProgWrite = 1'b0;
        nChecks++;
        if (cnt(1) !== 4'd6) begin
            nFail++; $display("FAIL write_load_old: count=%0d expected 6", cnt(1));
        end
        step();
        idle();
        nChecks++;
        if (cnt(1) !== 4'd2) begin
            nFail++; $display("FAIL write_load_new: count=%0d expected 2", cnt(1));
        end
    endtask

    task automatic test_load_override();
        int doneSeen;
        applyReset();
        bus.Load    = 4'b0100;
        bus.LoadSel = 8'h00;
        step();
        idle();
        step();
        step();
        step();
        nChecks++;
        if (cnt(2) !== 4'd1) begin
            nFail++; $display("FAIL override_pre: count=%0d expected 1", cnt(2));
        end
        bus.Load    = 4'b0100;
        bus.LoadSel = 8'h30;
        step();
        idle();
        nChecks++;
        if (cnt(2) !== 4'd4 || bus.Done[2] !== 1'b0) begin
            nFail++;
            $display("FAIL override_load: count=%0d done=%b expected 4/0", cnt(2), bus.Done[2]);
        end
        bus.Hold = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            nChecks++;
            if (cnt(2) !== 4'd4 || bus.Done[2] !== 1'b0) begin
                nFail++;
                $display("FAIL hold: count=%0d done=%b expected 4/0", cnt(2), bus.Done[2]);
            end
        end
        bus.Hold = '0;
        doneSeen = 0;
        for (int k = 3; k >= 0; k--) begin
            step();
            if (bus.Done[2] === 1'b1) doneSeen++;
            nChecks++;
            if (cnt(2) !== 4'(k)) begin
                nFail++; $display("FAIL release: count=%0d expected %0d", cnt(2), k);
            end
        end
        step();
        if (bus.Done[2] === 1'b1) doneSeen++;
        nChecks++;
        if (doneSeen !== 1) begin
            nFail++; $display("FAIL release_done: pulses=%0d expected 1", doneSeen);
        end
    endtask

    task automatic test_reset_midcount();
        applyReset();
        bus.Load    = 4'hF;
        bus.LoadSel = 8'hAA;
        step();
        idle();
        for (int k = 0; k < 4; k++) step();
        nChecks++;
        if (bus.CountOut !== 16'h3333) begin
            nFail++; $display("FAIL burst_all: got %h expected 3333", bus.CountOut);
        end
        // Load and ProgWrite alongside reset must be ignored
        reset           = 1'b1;
        bus.Load        = 4'hF;
        bus.ProgWrite   = 1'b1;
        bus.ProgSel     = 3'd0;
        bus.ProgramData = 10'd9;
        step();
        nChecks++;
        if (bus.CountOut !== '0 || bus.Done !== '0 || bus.Busy !== '0) begin
            nFail++;
            $display("FAIL midcount_reset: count=%h done=%b busy=%b expected 0/0/0",
                     bus.CountOut, bus.Done, bus.Busy);
        end
        reset = 1'b0;
        idle();
        bus.Load = 4'b0001;
        step();
        idle();
        nChecks++;
        if (cnt(0) !== 4'd4) begin
            nFail++; $display("FAIL reset_ignores_write: count=%0d expected 4", cnt(0));
        end
    endtask

    task automatic test_zero_load();
        applyReset();
        bus.ProgWrite   = 1'b1;
        bus.ProgSel     = 3'd3;
        bus.ProgramData = 10'd0;
        step();
        idle();
        bus.Load    = 4'b1000;
        bus.LoadSel = 8'hC0;
        step();
        idle();
        nChecks++;
        if (cnt(3) !== 4'd0 || bus.Done[3] !== 1'b1 || bus.Busy[3] !== 1'b0) begin
            nFail++;
            $display("FAIL zero_load: count=%0d done=%b busy=%b expected 0/1/0",
                     cnt(3), bus.Done[3], bus.Busy[3]);
        end
        step();
        nChecks++;
        if (bus.Done[3] !== 1'b0 || bus.Busy[3] !== 1'b0) begin
            nFail++;
            $display("FAIL zero_after: done=%b busy=%b expected 0/0", bus.Done[3], bus.Busy[3]);
        end
    endtask

    initial begin
        idle();
        @(negedge clock);
        test_reset();
        test_cas_countdown();
        test_program();
        test_write_load_same();
        test_load_override();
        test_reset_midcount();
        test_zero_load();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/sdram_timing_counter.md
SDRAM_TIMING_COUNTER -- requirements
Module: sdram_timing_counter

Interface
REQ-001 Parameter NCH, 4, number of independent timing channels (one per bank); legal 1..8.
REQ-002 Parameter CW, 4, counter width per channel; legal 3..8.
REQ-003 Parameter PW, 10, ProgramData width.
REQ-004 clock  input  1  single clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ProgramData  input  PW  timing value to write into the selected config register.
REQ-007 ProgWrite  input  1  write strobe for the config register file.
REQ-008 ProgSel  input  3  config select: 0 tPRE, 1 tCAS, 2 tBURST, 3 tWAIT, 4 tLAT; 5..7 ignored.
REQ-009 Load  input  NCH  per-channel load strobe.
REQ-010 LoadSel  input  2*NCH  per-channel timing select; channel i uses bits [2i+1:2i]: 0 tPRE, 1 tCAS, 2 tBURST, 3 tWAIT.
REQ-011 Hold  input  NCH  per-channel pause; freezes decrement only.
REQ-012 CountOut  output  CW*NCH  packed per-channel counts, channel i at [CW*i+CW-1:CW*i].
REQ-013 Done  output  NCH  per-channel one-cycle expiry pulse.
REQ-014 Busy  output  NCH  per-channel: count nonzero.
REQ-015 tLAT  output  2  programmed CAS latency, registered.

Function
REQ-016 Config registers tPRE, tCAS, tBURST, tWAIT SHALL each be CW bits; a write SHALL store ProgramData saturated to 2^CW-1 when it exceeds that value.
REQ-017 A write to tLAT SHALL store ProgramData[1:0].
REQ-018 A write SHALL take effect at the clock edge on which ProgWrite is sampled high; a Load in the same cycle SHALL use the pre-write value.
REQ-019 Channel update priority per edge SHALL be: reset, Load, decrement.
REQ-020 Load[i] high SHALL set count i to the selected config value, regardless of Hold[i] or the current count.
REQ-021 With Load[i] low, Hold[i] low and count i nonzero, count i SHALL decrement by 1.
REQ-022 Count i SHALL hold at 0; no wrap below 0.
REQ-023 Done[i] SHALL be registered and high for exactly the cycle in which count i first reads 0 after a decrement from 1, or after a Load of value 0.
REQ-024 A Load on the edge where count i would reach 0 SHALL suppress Done[i] for that edge.
REQ-025 Busy[i] SHALL equal (count i != 0), combinationally from the count register.
REQ-026 Channels SHALL be fully independent; simultaneous Loads on all channels SHALL all be honoured in the same cycle.

Reset
REQ-027 On reset all counts SHALL be 0; Done SHALL be 0; Busy SHALL therefore be 0.
REQ-028 On reset config SHALL be tPRE=4, tCAS=6, tBURST=7, tWAIT=4, tLAT=0 (legacy timing), saturated to CW bits.
REQ-029 Reset asserted mid-count SHALL clear the count on that edge with no Done pulse; Load and ProgWrite SHALL be ignored while reset is high.

Structure
REQ-030 Package sdram_timing_pkg SHALL hold ProgSel/LoadSel encodings and the default timing constants.
REQ-031 One channel counter SHALL be a sub-module sdram_tcount_chan (count, Done, Busy), instantiated NCH times with a generate loop; the config register file SHALL reside in the top level.

Verification
REQ-032 Reset, then Load[0] with LoadSel=1 -> CountOut[0] reads 6,5,4,3,2,1,0 on successive cycles; Done[0] high only in the cycle it reads 0.
REQ-033 ProgWrite with ProgSel=0, ProgramData=20, CW=4 -> tPRE reads back via Load as 15 (saturated); ProgSel=4, ProgramData=3 -> tLAT=3 on the next cycle.
REQ-034 ProgWrite tCAS=2 together with Load[1] of tCAS -> count 6 loaded; a following Load -> count 2.
REQ-035 Count at 1 with Load[2] (tWAIT) on the same edge -> count 4, no Done; Hold[2] for 3 cycles -> count stays 4; release -> count decrements to 0 with a single Done.
REQ-036 All channels loaded with tBURST simultaneously, reset asserted when counts read 3 -> all counts 0, Done 0, Busy 0 on the next cycle.
REQ-037 tWAIT programmed to 0, Load[3] -> count 0, Done[3] pulses one cycle, Busy[3] stays 0.
